// File: rtl/map_rom.sv
// map_rom: note-to-display character ROM.
// Maps a 6-bit semitone index (0..63) to two registered 9-bit character-LCD
// words: the note letter and the octave digit. Bit 8 of each word is RS_BIT.
// Optional feature macro: MAP_ROM_SHARP_EN. When it is defined, sharps are
// shown as an upper-case letter followed by '#' instead of a lower-case
// letter followed by the octave digit.
module map_rom #(
  parameter logic RS_BIT      = 1'b1,
  parameter int   BASE_OCTAVE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] note_idx,
  output logic [8:0] left_char,
  output logic [8:0] right_char
);

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_SHARP = 8'h23;
  localparam logic [7:0] DIGIT_BASE  = 8'(8'h30 + BASE_OCTAVE);

  logic [3:0] semitone;
  logic [2:0] octave;
  logic [7:0] letter;
  logic [7:0] natural_letter;
  logic       is_sharp;
  logic [7:0] digit;
  logic [8:0] left_next;
  logic [8:0] right_next;

  // Explicit 64-entry table splitting the index into semitone and octave
  always_comb begin
    semitone = 4'd0;
    octave   = 3'd0;
    case (note_idx)
      6'd0:  begin semitone = 4'd0;  octave = 3'd0; end
      6'd1:  begin semitone = 4'd1;  octave = 3'd0; end
      6'd2:  begin semitone = 4'd2;  octave = 3'd0; end
      6'd3:  begin semitone = 4'd3;  octave = 3'd0; end
      6'd4:  begin semitone = 4'd4;  octave = 3'd0; end
      6'd5:  begin semitone = 4'd5;  octave = 3'd0; end
      6'd6:  begin semitone = 4'd6;  octave = 3'd0; end
      6'd7:  begin semitone = 4'd7;  octave = 3'd0; end
      6'd8:  begin semitone = 4'd8;  octave = 3'd0; end
      6'd9:  begin semitone = 4'd9;  octave = 3'd0; end
      6'd10: begin semitone = 4'd10; octave = 3'd0; end
      6'd11: begin semitone = 4'd11; octave = 3'd0; end
      6'd12: begin semitone = 4'd0;  octave = 3'd1; end
      6'd13: begin semitone = 4'd1;  octave = 3'd1; end
      6'd14: begin semitone = 4'd2;  octave = 3'd1; end
      6'd15: begin semitone = 4'd3;  octave = 3'd1; end
      6'd16: begin semitone = 4'd4;  octave = 3'd1; end
      6'd17: begin semitone = 4'd5;  octave = 3'd1; end
      6'd18: begin semitone = 4'd6;  octave = 3'd1; end
      6'd19: begin semitone = 4'd7;  octave = 3'd1; end
      6'd20: begin semitone = 4'd8;  octave = 3'd1; end
      6'd21: begin semitone = 4'd9;  octave = 3'd1; end
      6'd22: begin semitone = 4'd10; octave = 3'd1; end
      6'd23: begin semitone = 4'd11; octave = 3'd1; end
      6'd24: begin semitone = 4'd0;  octave = 3'd2; end
      6'd25: begin semitone = 4'd1;  octave = 3'd2; end
      6'd26: begin semitone = 4'd2;  octave = 3'd2; end
      6'd27: begin semitone = 4'd3;  octave = 3'd2; end
      6'd28: begin semitone = 4'd4;  octave = 3'd2; end
      6'd29: begin semitone = 4'd5;  octave = 3'd2; end
      6'd30: begin semitone = 4'd6;  octave = 3'd2; end
      6'd31: begin semitone = 4'd7;  octave = 3'd2; end
      6'd32: begin semitone = 4'd8;  octave = 3'd2; end
      6'd33: begin semitone = 4'd9;  octave = 3'd2; end
      6'd34: begin semitone = 4'd10; octave = 3'd2; end
      6'd35: begin semitone = 4'd11; octave = 3'd2; end
      6'd36: begin semitone = 4'd0;  octave = 3'd3; end
      6'd37: begin semitone = 4'd1;  octave = 3'd3; end
      6'd38: begin semitone = 4'd2;  octave = 3'd3; end
      6'd39: begin semitone = 4'd3;  octave = 3'd3; end
      6'd40: begin semitone = 4'd4;  octave = 3'd3; end
      6'd41: begin semitone = 4'd5;  octave = 3'd3; end
      6'd42: begin semitone = 4'd6;  octave = 3'd3; end
      6'd43: begin semitone = 4'd7;  octave = 3'd3; end
      6'd44: begin semitone = 4'd8;  octave = 3'd3; end
      6'd45: begin semitone = 4'd9;  octave = 3'd3; end
      6'd46: begin semitone = 4'd10; octave = 3'd3; end
      6'd47: begin semitone = 4'd11; octave = 3'd3; end
      6'd48: begin semitone = 4'd0;  octave = 3'd4; end
      6'd49: begin semitone = 4'd1;  octave = 3'd4; end
      6'd50: begin semitone = 4'd2;  octave = 3'd4; end
      6'd51: begin semitone = 4'd3;  octave = 3'd4; end
      6'd52: begin semitone = 4'd4;  octave = 3'd4; end
      6'd53: begin semitone = 4'd5;  octave = 3'd4; end
      6'd54: begin semitone = 4'd6;  octave = 3'd4; end
      6'd55: begin semitone = 4'd7;  octave = 3'd4; end
      6'd56: begin semitone = 4'd8;  octave = 3'd4; end
      6'd57: begin semitone = 4'd9;  octave = 3'd4; end
      6'd58: begin semitone = 4'd10; octave = 3'd4; end
      6'd59: begin semitone = 4'd11; octave = 3'd4; end
      6'd60: begin semitone = 4'd0;  octave = 3'd5; end
      6'd61: begin semitone = 4'd1;  octave = 3'd5; end
      6'd62: begin semitone = 4'd2;  octave = 3'd5; end
      6'd63: begin semitone = 4'd3;  octave = 3'd5; end
      default: begin semitone = 4'd0; octave = 3'd0; end
    endcase
  end

  // Letter lookup: lower case marks a sharp; natural_letter is the note below
  always_comb begin
    letter         = "C";
    natural_letter = "C";
    is_sharp       = 1'b0;
    case (semitone)
      4'd0:  begin letter = "C"; natural_letter = "C"; is_sharp = 1'b0; end
      4'd1:  begin letter = "c"; natural_letter = "C"; is_sharp = 1'b1; end
      4'd2:  begin letter = "D"; natural_letter = "D"; is_sharp = 1'b0; end
      4'd3:  begin letter = "d"; natural_letter = "D"; is_sharp = 1'b1; end
      4'd4:  begin letter = "E"; natural_letter = "E"; is_sharp = 1'b0; end
      4'd5:  begin letter = "F"; natural_letter = "F"; is_sharp = 1'b0; end
      4'd6:  begin letter = "f"; natural_letter = "F"; is_sharp = 1'b1; end
      4'd7:  begin letter = "G"; natural_letter = "G"; is_sharp = 1'b0; end
      4'd8:  begin letter = "g"; natural_letter = "G"; is_sharp = 1'b1; end
      4'd9:  begin letter = "A"; natural_letter = "A"; is_sharp = 1'b0; end
      4'd10: begin letter = "a"; natural_letter = "A"; is_sharp = 1'b1; end
      4'd11: begin letter = "B"; natural_letter = "B"; is_sharp = 1'b0; end
      default: begin letter = "C"; natural_letter = "C"; is_sharp = 1'b0; end
    endcase
  end

  // Assemble the next display words; the sharp-sign variant hides the octave
  always_comb begin
    digit      = DIGIT_BASE + {5'd0, octave};
    left_next  = {RS_BIT, letter};
    right_next = {RS_BIT, digit};
`ifdef MAP_ROM_SHARP_EN
    if (is_sharp) begin
      left_next  = {RS_BIT, natural_letter};
      right_next = {RS_BIT, ASCII_SHARP};
    end
`else
    if (is_sharp && (natural_letter == ASCII_SPACE)) begin
      left_next = {RS_BIT, ASCII_SPACE};
    end
`endif
  end

  // Output registers; reset shows blanks so the LCD never sees garbage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_char  <= {RS_BIT, ASCII_SPACE};
      right_char <= {RS_BIT, ASCII_SPACE};
    end else begin
      left_char  <= left_next;
      right_char <= right_next;
    end
  end

endmodule

// File: tb/tb_map_rom.sv
// tb_map_rom: scoreboard bench for map_rom at default parameters.
// Follows MAP_ROM_SHARP_EN in its reference model when the macro is defined.
module tb_map_rom;

  localparam logic RS_BIT      = 1'b1;
  localparam int   BASE_OCTAVE = 0;

  logic       clk;
  logic       rst_n;
  logic [5:0] note_idx;
  logic [8:0] left_char;
  logic [8:0] right_char;

  int vectors;
  int miscompares;

  logic [17:0] exp_q[$];

  map_rom #(.RS_BIT(RS_BIT), .BASE_OCTAVE(BASE_OCTAVE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_idx  (note_idx),
    .left_char (left_char),
    .right_char(right_char)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 9'h%03h, expected 9'h%03h", tag, observed, expected);
    end
  endtask

  // Reference model built from mod/div arithmetic and a letter string
  function automatic logic [17:0] model(input logic [5:0] idx);
    string      letters  = "CcDdEFfGgAaB";
    string      naturals = "CCDDEFFGGAAB";
    int         s;
    int         o;
    logic [7:0] l;
    logic [7:0] r;
    s = int'(idx) % 12;
    o = int'(idx) / 12;
    l = letters[s];
    r = 8'(48 + BASE_OCTAVE + o);
`ifdef MAP_ROM_SHARP_EN
    if (s == 1 || s == 3 || s == 6 || s == 8 || s == 10) begin
      l = naturals[s];
      r = 8'h23;
    end
`else
    if (naturals.len() == 0) l = 8'h00;
`endif
    return {RS_BIT, l, RS_BIT, r};
  endfunction

  // Drive one index before an edge, push its expectation, compare after the edge
  task automatic applyStimulus(input logic [5:0] idx);
    logic [17:0] exp_word;
    @(negedge clk);
    note_idx = idx;
    exp_q.push_back(model(idx));
    @(posedge clk);
    #1;
    exp_word = exp_q.pop_front();
    checkOutput($sformatf("left[%0d]", idx), left_char, exp_word[17:9]);
    checkOutput($sformatf("right[%0d]", idx), right_char, exp_word[8:0]);
    checkOutput($sformatf("noX[%0d]", idx), {8'd0, $isunknown({left_char, right_char})}, 9'd0);
    checkOutput($sformatf("rs[%0d]", idx), {7'd0, left_char[8], right_char[8]}, {7'd0, RS_BIT, RS_BIT});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    note_idx    = 6'd7;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_left", left_char, 9'h120);
    checkOutput("reset_right", right_char, 9'h120);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed points with literal expected words
    applyStimulus(6'd0);
    checkOutput("d0_left", left_char, 9'h143);
    checkOutput("d0_right", right_char, 9'h130);
    applyStimulus(6'd1);
`ifdef MAP_ROM_SHARP_EN
    checkOutput("d1_left", left_char, 9'h143);
    checkOutput("d1_right", right_char, 9'h123);
`else
    checkOutput("d1_left", left_char, 9'h163);
    checkOutput("d1_right", right_char, 9'h130);
`endif
    applyStimulus(6'd11);
    checkOutput("d11_left", left_char, 9'h142);
    checkOutput("d11_right", right_char, 9'h130);
    applyStimulus(6'd12);
    checkOutput("d12_left", left_char, 9'h143);
    checkOutput("d12_right", right_char, 9'h131);
    applyStimulus(6'd63);
`ifndef MAP_ROM_SHARP_EN
    checkOutput("d63_left", left_char, 9'h164);
    checkOutput("d63_right", right_char, 9'h135);
`endif

    // Full sweep, one index per cycle
    for (int i = 0; i < 64; i++) applyStimulus(6'(i));

    // Random back-to-back indices
    for (int i = 0; i < 40; i++) applyStimulus(6'($urandom_range(0, 63)));

    // Asynchronous reset mid-cycle, then release mid-stream
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midreset_left", left_char, 9'h120);
    checkOutput("midreset_right", right_char, 9'h120);
    @(posedge clk);
    #1;
    checkOutput("heldreset_left", left_char, 9'h120);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(6'd5);
    checkOutput("release_left", left_char, 9'h146);
    checkOutput("release_right", right_char, 9'h130);
    applyStimulus(6'd42);

    checkOutput("queue_empty", 9'(exp_q.size()), 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
